mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage controller between the EX/MEM pipeline register and the external single-port data SRAM. It takes the registered memory read/write strobes, address and store data from EX/MEM and sequences a multi-cycle SRAM access. It drives `ready` low to freeze the whole pipeline until the access completes. It also holds load data for the MEM/WB register.

## Interface
- `WAIT_CYCLES`, 5: SRAM access latency in cycles, legal range 1..15.
- `ADDR_W`, 16: SRAM word-address width.

- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `memoryReadEnabled` in 1: load request from EX/MEM.
- `memoryWriteEnabled` in 1: store request from EX/MEM.
- `aluResult` in 32: byte address.
- `valRm` in 32: store data.
- `readData` out 32: load result, registered.
- `ready` out 1: 0 means freeze all pipeline registers and the PC.
- `sramAddr` out ADDR_W: word address, `aluResult[ADDR_W+1:2]`, registered.
- `sramWData` out 32: registered store data.
- `sramWe` out 1: write strobe, active-high.
- `sramRe` out 1: read strobe, active-high.
- `sramRData` in 32: SRAM read data, valid in the last BUSY cycle.

## Operation
- States are IDLE, BUSY and DONE. A 4-bit wait counter is used.
- `req` = `memoryReadEnabled | memoryWriteEnabled`.
- If both strobes are high, the read wins. This case is illegal upstream; the write is dropped.
- IDLE with `req` high:
  - Latch address, store data and direction.
  - Load counter with `WAIT_CYCLES-1`.
  - Go to BUSY.
- IDLE with `req` low: stay in IDLE.
- BUSY:
  - `sramRe` or `sramWe` is held high for the whole state; address and data are stable.
  - Counter decrements each cycle.
  - At counter 0, a read captures `sramRData` into `readData`. Then go to DONE.
- DONE: go to IDLE unconditionally. Requests are ignored. The EX/MEM inputs still show the completed instruction this cycle, so this rule prevents a double access.
- `ready` = (IDLE and not `req`) or DONE. It is combinational from state and `req`.
- `readData` holds its value until the next read completes. Writes never change it.
- `aluResult` bits [1:0] and bits above ADDR_W+1 are ignored.

## Timing
- Reset values of all outputs are 0, except `ready`. `ready` is 1 whenever `req` is low during reset. The state returns to IDLE.
- Request first seen at cycle 0, with `ready`=0 in the same cycle.
- BUSY covers cycles 1..WAIT_CYCLES.
- DONE is at cycle WAIT_CYCLES+1, with `ready`=1. The pipeline advances at the end of this cycle.
- Total freeze is WAIT_CYCLES+1 cycles.
- Back-to-back requests: the next access starts in the IDLE cycle after DONE. The minimum spacing is WAIT_CYCLES+2 cycles.
- With WAIT_CYCLES=1, BUSY lasts exactly one cycle.
- Reset asserted mid-access:
  - All state clears immediately and asynchronously.
  - The strobes drop, and a partial SRAM write is abandoned.
  - `readData` is cleared to 0.

## Configuration
- `MEM_CTRL_POSTED_WRITE_EN`
- Defined:
  - A store accepted in IDLE does not freeze the pipeline; `ready` stays 1.
  - The access proceeds in BUSY with a posted flag set.
  - While a posted write is in BUSY, `ready`=1 if `req` is low. If `req` is high, `ready`=0 and the new request is held off.
  - A posted write goes from its last BUSY cycle straight to IDLE, skipping DONE.
  - A held request is then started from IDLE in the following cycle.
- Undefined: stores freeze the pipeline exactly as loads do, and the posted flag does not exist.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum (IDLE/BUSY/DONE, 2 bits);
  - the `WAIT_CYCLES` default;
  - the counter width (4).
- Sub-module `wait_counter`: a loadable down-counter with a zero flag and asynchronous active-low clear. It is instantiated once.
- Output registers use the existing parameterised `Register`, extended with active-low reset.

## Test plan
- Load at address 0x0000_0040 with `sramRData`=0xDEADBEEF:
  - `ready` low for 6 cycles;
  - `sramAddr`=0x0010;
  - `readData`=0xDEADBEEF from cycle 6.
- Store of `valRm`=0x1234_5678 to 0x0000_0008:
  - `sramWe` high in cycles 1-5 with `sramAddr`=0x0002;
  - `readData` unchanged.
- Load held through DONE, then a new load one cycle later: exactly two SRAM read bursts, no third access.
- Reset asserted in cycle 3 of a store:
  - `sramWe` drops the same cycle;
  - state returns to IDLE;
  - `ready`=1 with `req` low after release.
- `MEM_CTRL_POSTED_WRITE_EN` store followed by a load two cycles later:
  - `ready` stays 1 through the store;
  - `ready` drops when the load arrives;
  - the load starts in cycle 6 and `ready` returns in cycle 12.
- Both strobes high at once: only `sramRe` is asserted; no write occurs.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory-stage controller.
package mem_ctrl_pkg;

  // Controller states; 2-bit encoding, one code left unused.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memState;

  // Default SRAM access latency in cycles (legal 1..15).
  localparam int WAIT_CYCLES_DEFAULT = 5;

  // Width of the wait counter; holds WAIT_CYCLES-1 for the full legal range.
  localparam int CNT_W = 4;

  // Counter preload: the counter reaches zero in the last BUSY cycle.
  function automatic logic [CNT_W-1:0] waitPreload(input int waitCycles);
    return CNT_W'(waitCycles - 1);
  endfunction

endpackage

// File: rtl/Register.sv
// Register: parameterised enable register with asynchronous active-low clear.
module Register #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Capture d when enabled; clear to zero while reset is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter with zero flag and asynchronous
// active-low clear. Decrement saturates at zero.
module wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load takes priority over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: sequences a multi-cycle access to the single-port data SRAM
// for the instruction in EX/MEM, freezing the pipeline through ready=0 until
// the access completes, and holds load data for MEM/WB.
// Optional build macro MEM_CTRL_POSTED_WRITE_EN: stores run in the background
// without freezing the pipeline; a following request waits until the SRAM is free.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memoryReadEnabled,
  input  logic              memoryWriteEnabled,
  input  logic [31:0]       aluResult,
  input  logic [31:0]       valRm,
  output logic [31:0]       readData,
  output logic              ready,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [31:0]       sramWData,
  output logic              sramWe,
  output logic              sramRe,
  input  logic [31:0]       sramRData
);

  localparam logic [CNT_W-1:0] LOAD_VALUE = waitPreload(WAIT_CYCLES);

  memState state;
  memState stateNext;
  logic    req;
  logic    accept;
  logic    inBusy;
  logic    cntZero;
  logic    isRead;
  logic    captureRead;
  logic    unusedAddrBits;

  assign req         = memoryReadEnabled | memoryWriteEnabled;
  assign accept      = (state == IDLE) && req;
  assign inBusy      = (state == BUSY);
  assign captureRead = inBusy && cntZero && isRead;

  // Byte-offset bits and bits above the SRAM word address carry no meaning here.
  assign unusedAddrBits = ^aluResult;

  wait_counter uWaitCounter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .loadValue (LOAD_VALUE),
    .dec       (inBusy),
    .zero      (cntZero)
  );

  // Access direction, latched at acceptance; both strobes high resolves to a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isRead <= 1'b0;
    end else if (accept) begin
      isRead <= memoryReadEnabled;
    end
  end

`ifdef MEM_CTRL_POSTED_WRITE_EN
  logic posted;

  // Posted flag: a pure store proceeds while the pipeline keeps moving.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      posted <= 1'b0;
    end else if (accept) begin
      posted <= !memoryReadEnabled;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and pipeline freeze; DONE ignores req so a held instruction is not re-issued.
  always_comb begin
    stateNext = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stateNext = BUSY;
        end
`ifdef MEM_CTRL_POSTED_WRITE_EN
        ready = !memoryReadEnabled;
`else
        ready = !req;
`endif
      end
      BUSY: begin
`ifdef MEM_CTRL_POSTED_WRITE_EN
        if (cntZero) begin
          stateNext = posted ? IDLE : DONE;
        end
        ready = posted && !req;
`else
        if (cntZero) begin
          stateNext = DONE;
        end
`endif
      end
      DONE: begin
        stateNext = IDLE;
        ready     = 1'b1;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Strobes follow the state directly so reset drops them without waiting for a clock.
  assign sramRe = inBusy && isRead;
  assign sramWe = inBusy && !isRead;

  Register #(.DATA_W(ADDR_W)) uAddrReg (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .d   (aluResult[ADDR_W+1:2]),
    .q   (sramAddr)
  );

  Register #(.DATA_W(32)) uWDataReg (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .d   (valRm),
    .q   (sramWData)
  );

  Register #(.DATA_W(32)) uReadDataReg (
    .clk (clk),
    .rst (rst),
    .en  (captureRead),
    .d   (sramRData),
    .q   (readData)
  );

endmodule
